// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, iteration count.
package mips_pkg;

    localparam int unsigned MD_W     = 32;
    localparam int unsigned MD_ITER  = 32;
    localparam int unsigned MD_CNT_W = 5;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_t;

    // Two's-complement magnitude when neg is set, pass-through otherwise.
    function automatic logic [MD_W-1:0] md_mag(input logic [MD_W-1:0] x, input logic neg);
        return neg ? MD_W'(-x) : x;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle shift-add multiplier / restoring divider with HI/LO registers.
module mult_div_unit
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [MD_W-1:0] rs_val,
    input  logic [MD_W-1:0] rt_val,
    input  logic            mthi,
    input  logic            mtlo,
    output logic [MD_W-1:0] hi,
    output logic [MD_W-1:0] lo,
    output logic            busy,
    output logic            done
);

    md_state_t             state, state_nxt;
    logic [MD_CNT_W-1:0]   count, count_nxt;
    logic [2*MD_W-1:0]     acc, acc_nxt;
    logic [MD_W-1:0]       opnd, opnd_nxt;
    logic                  is_div, is_div_nxt;
    logic                  sign_rs, sign_rs_nxt;
    logic                  sign_rt, sign_rt_nxt;
    logic [MD_W-1:0]       hi_nxt, lo_nxt;
    logic                  busy_nxt, done_nxt;

    logic                  op_signed;
    logic [MD_W-1:0]       rs_mag, rt_mag;
    logic [MD_W:0]         mul_sum;
    logic [MD_W:0]         div_rem;
    logic                  div_ge;
    logic [MD_W-1:0]       div_sub;
    logic [2*MD_W-1:0]     prod_fix;
    logic                  neg_res;

    assign op_signed = ~op[0];
    assign rs_mag    = md_mag(rs_val, op_signed & rs_val[MD_W-1]);
    assign rt_mag    = md_mag(rt_val, op_signed & rt_val[MD_W-1]);

    // Shift-add step: accumulate multiplicand into the upper half when the low bit is set.
    assign mul_sum   = {1'b0, acc[2*MD_W-1:MD_W]} + {1'b0, opnd};

    // Restoring step: shifted partial remainder (33 bits) against the divisor.
    assign div_rem   = acc[2*MD_W-1:MD_W-1];
    assign div_ge    = div_rem >= {1'b0, opnd};
    assign div_sub   = div_rem[MD_W-1:0] - opnd;

    assign neg_res   = sign_rs ^ sign_rt;
    assign prod_fix  = neg_res ? (2*MD_W)'(-acc) : acc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= MD_IDLE;
            count   <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            sign_rs <= 1'b0;
            sign_rt <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            acc     <= acc_nxt;
            opnd    <= opnd_nxt;
            is_div  <= is_div_nxt;
            sign_rs <= sign_rs_nxt;
            sign_rt <= sign_rt_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        acc_nxt     = acc;
        opnd_nxt    = opnd;
        is_div_nxt  = is_div;
        sign_rs_nxt = sign_rs;
        sign_rt_nxt = sign_rt;
        hi_nxt      = hi;
        lo_nxt      = lo;
        done_nxt    = 1'b0;

        case (state)
            MD_IDLE: begin
                if (start) begin
                    is_div_nxt  = op[1];
                    sign_rs_nxt = op_signed & rs_val[MD_W-1];
                    sign_rt_nxt = op_signed & rt_val[MD_W-1];
                    // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
                    acc_nxt     = {{MD_W{1'b0}}, (op[1] ? rs_mag : rt_mag)};
                    opnd_nxt    = op[1] ? rt_mag : rs_mag;
                    count_nxt   = '0;
                    state_nxt   = MD_RUN;
                end else begin
                    if (mthi) hi_nxt = rs_val;
                    if (mtlo) lo_nxt = rs_val;
                end
            end
            MD_RUN: begin
                if (is_div) begin
                    acc_nxt = div_ge ? {div_sub, acc[MD_W-2:0], 1'b1}
                                     : {acc[2*MD_W-2:0], 1'b0};
                end else begin
                    acc_nxt = acc[0] ? {mul_sum, acc[MD_W-1:1]}
                                     : {1'b0, acc[2*MD_W-1:1]};
                end
                count_nxt = MD_CNT_W'(count + 1'b1);
                if (count == MD_CNT_W'(MD_ITER - 1)) state_nxt = MD_FIX;
            end
            MD_FIX: begin
                if (is_div) begin
                    // Divide by zero leaves the dividend magnitude as remainder; quotient forced to all ones.
                    lo_nxt = (opnd == '0) ? {MD_W{1'b1}} : md_mag(acc[MD_W-1:0], neg_res);
                    hi_nxt = md_mag(acc[2*MD_W-1:MD_W], sign_rs);
                end else begin
                    lo_nxt = prod_fix[MD_W-1:0];
                    hi_nxt = prod_fix[2*MD_W-1:MD_W];
                end
                done_nxt  = 1'b1;
                state_nxt = MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase

        busy_nxt = (state_nxt != MD_IDLE);
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;
    int bd_err;

    mult_div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy && done) bd_err++;
    endtask

    // Launch op at the next edge and wait (bounded) for done; n = edges after launch edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        tick();
        start  = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
        int n;
        run_op(o, a, b, n);
        n_checks++;
        if (n !== 33) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges after launch, want 33", name, n);
        end
        n_checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_fail++;
            $display("FAIL %s result: hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b, want 0 0 0 0", hi, lo, busy, done);
        end
    endtask

    task automatic test_mthi_mtlo();
        rs_val = 32'hA5A5A5A5;
        mthi = 1'b1;
        mtlo = 1'b1;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        n_checks++;
        if (hi !== 32'hA5A5A5A5 || lo !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h, want a5a5a5a5 a5a5a5a5", hi, lo);
        end
        rs_val = 32'h12345678;
        mtlo = 1'b1;
        tick();
        mtlo = 1'b0;
        n_checks++;
        if (hi !== 32'hA5A5A5A5 || lo !== 32'h12345678) begin
            n_fail++;
            $display("FAIL mtlo_only: hi=%h lo=%h, want a5a5a5a5 12345678", hi, lo);
        end
    endtask

    task automatic test_multiply();
        check_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        check_op("mult_neg3x5", 2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
        check_op("mult_minmin", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        check_op("mult_negneg", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000000, 32'h00000002);
    endtask

    task automatic test_divide();
        check_op("div_neg7_2",  2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        check_op("div_7_neg2",  2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        check_op("divu_by0",    2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF);
        check_op("div_neg_by0", 2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF);
        check_op("div_min_m1",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        check_op("divu_big",    2'b11, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000001);
    endtask

    task automatic test_ignore_busy();
        int pulses;
        int done_at;
        start  = 1'b1;
        op     = 2'b11;
        rs_val = 32'd7;
        rt_val = 32'd2;
        tick();
        start  = 1'b0;
        pulses = 0;
        done_at = -1;
        for (int i = 1; i <= 45; i++) begin
            if (i == 10) begin
                start  = 1'b1;
                op     = 2'b01;
                rs_val = 32'd9;
                rt_val = 32'd9;
                mthi   = 1'b1;
            end else begin
                start  = 1'b0;
                mthi   = 1'b0;
            end
            tick();
            if (done) begin
                pulses++;
                if (done_at < 0) done_at = i;
            end
        end
        n_checks++;
        if (pulses !== 1 || done_at !== 33) begin
            n_fail++;
            $display("FAIL ignore_busy_done: pulses=%0d at=%0d, want 1 at 33", pulses, done_at);
        end
        n_checks++;
        if (hi !== 32'd1 || lo !== 32'd3) begin
            n_fail++;
            $display("FAIL ignore_busy_result: hi=%h lo=%h, want 1 3", hi, lo);
        end
    endtask

    task automatic test_reset_mid_op();
        start  = 1'b1;
        op     = 2'b01;
        rs_val = 32'd6;
        rt_val = 32'd7;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_op_idle: busy=%b done=%b, want 0 0", busy, done);
        end
        check_op("multu_6x7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
    endtask

    task automatic test_start_with_mthi();
        int n;
        mthi = 1'b1;
        start = 1'b1;
        op = 2'b01;
        rs_val = 32'd2;
        rt_val = 32'd3;
        tick();
        mthi = 1'b0;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || hi !== 32'd0) begin
            n_fail++;
            $display("FAIL start_mthi_launch: busy=%b hi=%h, want 1 0", busy, hi);
        end
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 33 || lo !== 32'd6 || hi !== 32'd0) begin
            n_fail++;
            $display("FAIL start_mthi_result: n=%0d hi=%h lo=%h, want 33 0 6", n, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        check_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        // still in the done cycle here; relaunch immediately
        start  = 1'b1;
        op     = 2'b10;
        rs_val = 32'hFFFFFF9C;
        rt_val = 32'd7;
        tick();
        start  = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_launch: busy=%b done=%b, want 1 0", busy, done);
        end
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 33 || hi !== 32'hFFFFFFFE || lo !== 32'hFFFFFFF2) begin
            n_fail++;
            $display("FAIL b2b_result: n=%0d hi=%h lo=%h, want 33 fffffffe fffffff2", n, hi, lo);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bd_err   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        rs_val   = 32'h0;
        rt_val   = 32'h0;
        mthi     = 1'b0;
        mtlo     = 1'b0;

        test_reset();
        test_mthi_mtlo();
        test_multiply();
        test_divide();
        test_ignore_busy();
        test_reset_mid_op();
        test_start_with_mthi();
        test_back_to_back();

        n_checks++;
        if (bd_err !== 0) begin
            n_fail++;
            $display("FAIL busy_done_overlap: %0d cycles with both set, want 0", bd_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
